// File: rtl/dir_pkg.sv
// Direction encoding shared by the command queue, the game logic and the AI.
// reverse() gives the opposite heading: up<->down, right<->left.
package dir_pkg;
    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_RIGHT = 2'b01;
    localparam dir_t DIR_DOWN  = 2'b10;
    localparam dir_t DIR_LEFT  = 2'b11;

    function automatic dir_t reverse(input dir_t d);
        return d ^ 2'b10;
    endfunction
endpackage

// File: rtl/dir_fifo.sv
// Small synchronous FIFO of directions with flush, exposing head, tail and count.
// Head and tail are read combinationally so a pop and the push filter see them in the same cycle.
module dir_fifo
    import dir_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  dir_t                   i_data,
    output dir_t                   o_head,
    output dir_t                   o_tail,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    dir_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_tail  = r_mem[r_wr_ptr - 1'b1];

    // A pop frees a slot, so a push into a full FIFO is legal in the same cycle.
    assign w_pop  = i_pop && !o_empty && !i_flush;
    assign w_push = i_push && (!o_full || w_pop) && !i_flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/dir_cmd_queue.sv
// Filters and buffers key direction events, generates the game step tick and
// applies one queued (or AI-proposed) direction per step.
module dir_cmd_queue
    import dir_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int STEP_CYCLES = 10_000_000,
    parameter int DROP_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   key_valid,
    input  logic [1:0]             key_dir,
    input  logic                   ai_mode,
    input  logic [1:0]             ai_dir,
    input  logic                   pause,
    output logic                   step,
    output logic [1:0]             dir,
    output logic [$clog2(DEPTH):0] q_count,
    output logic [DROP_W-1:0]      drop_cnt
);
    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic [TW-1:0]     r_timer;
    logic              r_step;
    dir_t              r_dir;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              r_ai_mode_d;

    dir_t w_head;
    dir_t w_tail;
    dir_t w_ref;
    dir_t w_dir_next;
    logic w_full;
    logic w_empty;
    logic w_tick;
    logic w_flush;
    logic w_key_ok;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_tick  = !pause && (r_timer == TW'(STEP_CYCLES - 1));
    assign w_flush = (ai_mode != r_ai_mode_d);

    // New keys are judged against the last queued direction, or the applied one if the queue is empty.
    assign w_ref    = w_empty ? r_dir : w_tail;
    assign w_key_ok = key_valid && !ai_mode && (key_dir != w_ref) && (key_dir != reverse(w_ref));

    assign w_pop  = w_tick && !ai_mode && !w_empty && !w_flush;
    assign w_push = w_key_ok && (!w_full || w_pop) && !w_flush;
    assign w_drop = w_key_ok && w_full && !w_pop && !w_flush;

    always_comb begin
        w_dir_next = r_dir;
        if (w_tick) begin
            if (ai_mode) begin
                if (ai_dir != reverse(r_dir)) w_dir_next = ai_dir;
            end else if (w_pop) begin
                w_dir_next = w_head;
            end
        end
    end

    dir_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (key_dir),
        .o_head  (w_head),
        .o_tail  (w_tail),
        .o_count (q_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer     <= '0;
            r_step      <= 1'b0;
            r_dir       <= DIR_RIGHT;
            r_drop_cnt  <= '0;
            r_ai_mode_d <= 1'b0;
        end else begin
            if (!pause) r_timer <= w_tick ? '0 : r_timer + 1'b1;
            r_step      <= w_tick;
            r_dir       <= w_dir_next;
            r_ai_mode_d <= ai_mode;
            if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign step     = r_step;
    assign dir      = r_dir;
    assign drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_dir_cmd_queue.sv
// Scoreboard bench for dir_cmd_queue: expected directions are queued as keys are
// driven and compared against dir whenever a step pulse appears.
module tb_dir_cmd_queue;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [1:0] key_dir = 2'b00;
    logic       ai_mode = 1'b0;
    logic [1:0] ai_dir = 2'b00;
    logic       pause = 1'b0;
    logic       step;
    logic [1:0] dir;
    logic [2:0] q_count;
    logic [7:0] drop_cnt;

    int         n_checks = 0;
    int         n_fails  = 0;
    logic [1:0] exp_q[$];
    logic [1:0] exp_dir = 2'b01;

    dir_cmd_queue #(.DEPTH(4), .STEP_CYCLES(8), .DROP_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_dir   (key_dir),
        .ai_mode   (ai_mode),
        .ai_dir    (ai_dir),
        .pause     (pause),
        .step      (step),
        .dir       (dir),
        .q_count   (q_count),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [1:0] d);
        key_valid = 1'b1;
        key_dir   = d;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic wait_step();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (step) seen = 1;
        end
        if (!seen) check("wait_step timeout", 0, 1);
    endtask

    // Every step pulse releases the next expected direction, or holds the current one.
    always @(posedge clk) begin
        #1;
        if (rst_n && step) begin
            if (exp_q.size() > 0) exp_dir = exp_q.pop_front();
            check("dir on step", dir, exp_dir);
        end
    end

    initial begin
        int n_steps;
        bit any_step;

        // 1: reset state and free-running step timer
        #12;
        check("reset dir", dir, 2'b01);
        check("reset q_count", q_count, 0);
        check("reset drop_cnt", drop_cnt, 0);
        check("reset step", step, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_steps = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_steps += int'(step);
            if (k == 8)  check("t1 step at 8", step, 1);
            if (k == 16) check("t1 step at 16", step, 1);
        end
        check("t1 step count", n_steps, 2);
        check("t1 q_count", q_count, 0);

        // 2: reverse and duplicate filtered, valid key applied on next step
        wait_step();
        key(2'b11);
        check("t2 reverse filtered", q_count, 0);
        key(2'b01);
        check("t2 duplicate filtered", q_count, 0);
        exp_q.push_back(2'b00);
        key(2'b00);
        check("t2 accepted", q_count, 1);
        wait_step();
        check("t2 drained", q_count, 0);
        exp_q.push_back(2'b01);
        key(2'b01);
        wait_step();

        // 3: fill to four, fifth key dropped
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b11);
        key(2'b00);
        key(2'b01);
        key(2'b10);
        key(2'b11);
        check("t3 full", q_count, 4);
        key(2'b00);
        check("t3 drop_cnt", drop_cnt, 1);
        check("t3 still full", q_count, 4);

        // 4: push on the step edge while full is accepted
        tick();
        tick();
        exp_q.push_back(2'b10);
        key(2'b10);
        check("t4 step edge", step, 1);
        check("t4 q_count held", q_count, 4);
        check("t4 drop_cnt held", drop_cnt, 1);
        for (int i = 0; i < 4; i++) wait_step();
        check("t4 drained", q_count, 0);

        // 5: AI mode flushes queue, ignores keys, rejects reversal
        exp_q.push_back(2'b01);
        key(2'b01);
        wait_step();
        key(2'b00);
        key(2'b01);
        check("t5 q_count before ai", q_count, 2);
        ai_mode = 1'b1;
        ai_dir  = 2'b11;
        key(2'b10);
        check("t5 flushed", q_count, 0);
        key(2'b00);
        check("t5 key ignored", q_count, 0);
        wait_step();
        exp_q.push_back(2'b00);
        ai_dir = 2'b00;
        wait_step();
        ai_mode = 1'b0;
        tick();
        check("t5 dir kept on mode exit", dir, 2'b00);

        // 6: pause freezes timer but accepts keys, then async reset
        wait_step();
        tick();
        tick();
        tick();
        pause = 1'b1;
        exp_q.push_back(2'b11);
        key(2'b11);
        check("t6 push while paused", q_count, 1);
        any_step = 0;
        for (int i = 0; i < 29; i++) begin
            tick();
            if (step) any_step = 1;
        end
        check("t6 no step while paused", any_step, 0);
        pause = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (step) any_step = 1;
        end
        check("t6 timer held", any_step, 0);
        tick();
        check("t6 step after resume", step, 1);
        check("t6 popped", q_count, 0);
        key(2'b00);
        check("t6 q before reset", q_count, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 async dir", dir, 2'b01);
        check("t6 async q_count", q_count, 0);
        check("t6 async drop_cnt", drop_cnt, 0);
        check("t6 async step", step, 0);
        check("scoreboard empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/dir_cmd_queue.md
Name: dir_cmd_queue

Overview:
Upstream of game_single. Buffers one-cycle direction key events from the keyboard decoder into a small FIFO. Filters out reversal and duplicate commands. Generates the game step tick, and on each tick releases exactly one direction to the game logic. In AI mode the keyboard path is bypassed and ai_dir is sampled instead.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
STEP_CYCLES, 10_000_000, clk cycles per game step (100 MHz -> 10 steps/s)
DROP_W, 8, width of saturating drop counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_valid  in  1  single-cycle pulse, key_dir valid
key_dir  in  2  00 up, 01 right, 10 down, 11 left
ai_mode  in  1  1 = ignore keys, use ai_dir (already debounced switch)
ai_dir  in  2  direction proposed by AI, same encoding
pause  in  1  1 = freeze step timer
step  out  1  one-cycle pulse per game step
dir  out  2  current applied direction, valid from the cycle after step onward
q_count  out  $clog2(DEPTH)+1  FIFO occupancy
drop_cnt  out  DROP_W  rejected-because-full count, saturating

Behaviour:
- Reset (async on rst_n low): dir=01 (right), q_count=0, FIFO pointers=0, timer=0, step=0, drop_cnt=0, ai_mode_d=0.
- reverse(d) = d ^ 2'b10.
- Push reference ref = tail entry if q_count!=0 at start of cycle, else dir.
- Push conditions:
  - On key_valid && !ai_mode, push key_dir if key_dir!=ref and key_dir!=reverse(ref).
  - Filtered keys are silently ignored and do not count as drops.
  - If a push is valid but the FIFO is full and no pop occurs in the same cycle: drop the key; drop_cnt+1, saturating at all-ones.
- Step timer:
  - Counts 0..STEP_CYCLES-1 while pause=0 and holds while pause=1.
  - At count STEP_CYCLES-1 with pause=0: step=1 that cycle (registered, so visible the next cycle is acceptable only if dir updates on the same edge as step rises), and the timer wraps to 0.
  - Rule: step and the new dir become visible on the same clock edge.
- Pop on step:
  - ai_mode=0, q_count!=0: dir <= head, pop.
  - ai_mode=0, q_count==0: dir unchanged.
  - ai_mode=1: dir <= ai_dir unless ai_dir==reverse(dir), in which case dir is unchanged. No pop.
- Simultaneous push and pop: both happen and q_count is unchanged. When full, the push is accepted because the pop frees a slot. ref still uses the pre-cycle tail.
- Mode change: ai_mode is registered into ai_mode_d. Any edge of ai_mode (ai_mode != ai_mode_d) flushes the FIFO (q_count=0) that cycle. The flush overrides a same-cycle push or pop. dir and the timer are unaffected.
- pause=1: no step, no pop. Pushes are still accepted and filtered normally.
- Pointers wrap modulo DEPTH. q_count ranges 0..DEPTH.
- Latency: key accepted at edge N is visible in q_count at N+1. It is applied to dir at the first step edge at or after N+1.

Decomposition:
- Shared package dir_pkg: DIR_UP/RIGHT/DOWN/LEFT constants, the 2-bit dir type, and a reverse() function. game_single and the AI reuse the same package.
- One natural sub-module: dir_fifo.
  - Synchronous FIFO with DEPTH, push/pop/flush, head/tail/count.
  - The filter, timer, and mode logic stay in dir_cmd_queue.

Test Plan:
Bench uses STEP_CYCLES=8, DEPTH=4.
1. Reset, idle 20 cycles -> dir=01, step pulses at cycles 8 and 16 after release, q_count=0, drop_cnt=0.
2. dir=01, key 11 (reverse) then 01 (duplicate) -> q_count stays 0. Key 00 -> q_count=1. Next step -> dir=00, q_count=0.
3. Keys 00,01,10,11,00 in consecutive cycles with no step pending -> first four accepted (q_count=4), fifth dropped (drop_cnt=1). Following steps yield dir 00,01,10,11.
4. Push key coinciding with the step cycle while the FIFO is full -> push accepted, q_count stays 4, drop_cnt unchanged.
5. ai_mode 0->1 with q_count=2 -> q_count=0 next cycle. ai_dir=11 while dir=01 -> step keeps 01. ai_dir=00 -> next step dir=00. Keys are ignored throughout.
6. pause=1 for 30 cycles mid-count -> no step, timer holds. Assert rst_n low mid-operation -> all outputs return to reset values immediately, asynchronously.
